// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage hazard detection and operand forwarding control.
//   A three-entry scoreboard (EX, MEM, WB) holds {vld, rd, ld} for each in-flight producer.
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   id_valid              IF/ID holds a real instruction
//   IF_ID_rs1/2, id_uses  ID source registers and whether each is read
//   id_rd, id_reg_write   ID destination register and write enable
//   id_is_load            ID instruction is a load
//   forward_comp1/2       operand select: 00 regfile, 01 alu_out, 10 MEM result, 11 WB data
//   pc_write_en, IF_ID_write_en, ID_EX_bubble   load-use stall controls
//   stall_cnt             saturating count of stall cycles since reset
module id_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    output logic [1:0]                forward_comp1,
    output logic [1:0]                forward_comp2,
    output logic                      pc_write_en,
    output logic                      IF_ID_write_en,
    output logic                      ID_EX_bubble,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);
    typedef struct packed {
        logic                      vld;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      ld;
    } sb_t;
    sb_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb, stall;
    always_comb begin
        m1_ex  = id_valid & id_uses_rs1 & ex_q.vld  & (IF_ID_rs1 == ex_q.rd);
        m1_mem = id_valid & id_uses_rs1 & mem_q.vld & (IF_ID_rs1 == mem_q.rd);
        m1_wb  = id_valid & id_uses_rs1 & wb_q.vld  & (IF_ID_rs1 == wb_q.rd);
        m2_ex  = id_valid & id_uses_rs2 & ex_q.vld  & (IF_ID_rs2 == ex_q.rd);
        m2_mem = id_valid & id_uses_rs2 & mem_q.vld & (IF_ID_rs2 == mem_q.rd);
        m2_wb  = id_valid & id_uses_rs2 & wb_q.vld  & (IF_ID_rs2 == wb_q.rd);
        stall  = (m1_ex | m2_ex) & ex_q.ld;
        // youngest producer wins; a load still in EX cannot forward, select parks at 00
        forward_comp1 = m1_ex ? (ex_q.ld ? 2'b00 : 2'b01) : m1_mem ? 2'b10 : m1_wb ? 2'b11 : 2'b00;
        forward_comp2 = m2_ex ? (ex_q.ld ? 2'b00 : 2'b01) : m2_mem ? 2'b10 : m2_wb ? 2'b11 : 2'b00;
        pc_write_en    = ~stall;
        IF_ID_write_en = ~stall;
        ID_EX_bubble   = stall;
        // x0 is never recorded as valid so it can never match
        ex_d  = stall ? '0 : '{vld: id_valid & id_reg_write & (id_rd != '0), rd: id_rd, ld: id_is_load};
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = (stall & ~&cnt_q) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        stall_cnt = cnt_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed self-checking bench for id_hazard_ctrl.
//   Inputs change just after the falling edge; outputs are checked 1 time unit later.
//   A second instance with a 4-bit counter exercises saturation in a short run.
module tb_id_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] IF_ID_rs1 = '0, IF_ID_rs2 = '0, id_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_reg_write = 1'b0, id_is_load = 1'b0;
    logic [1:0] fc1, fc2, s_fc1, s_fc2;
    logic       pcw, ifw, bub, s_pcw, s_ifw, s_bub;
    logic [15:0] cnt;
    logic [3:0]  s_cnt;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .forward_comp1(fc1), .forward_comp2(fc2), .pc_write_en(pcw),
        .IF_ID_write_en(ifw), .ID_EX_bubble(bub), .stall_cnt(cnt));

    id_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .forward_comp1(s_fc1), .forward_comp2(s_fc2), .pc_write_en(s_pcw),
        .IF_ID_write_en(s_ifw), .ID_EX_bubble(s_bub), .stall_cnt(s_cnt));

    // present one ID instruction for a cycle; outputs are stable on return
    task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
        @(negedge clk);
        id_valid = v; IF_ID_rs1 = r1; IF_ID_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_is_load = ld;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        id_valid = 1'b0; IF_ID_rs1 = '0; IF_ID_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fc1 !== 2'b00) begin errors++; $display("FAIL reset_fc1 got=%b exp=00", fc1); end
        checks++; if (fc2 !== 2'b00) begin errors++; $display("FAIL reset_fc2 got=%b exp=00", fc2); end
        checks++; if ({pcw, ifw, bub} !== 3'b110) begin errors++; $display("FAIL reset_ctrl got=%b exp=110", {pcw, ifw, bub}); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_alu_alu();
        do_reset();
        issue(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);   // add x5,x1,x2
        checks++; if (fc1 !== 2'b00) begin errors++; $display("FAIL alu_first_fc1 got=%b exp=00", fc1); end
        issue(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);   // add x6,x5,x1
        checks++; if (fc1 !== 2'b01) begin errors++; $display("FAIL alu_fc1 got=%b exp=01", fc1); end
        checks++; if (fc2 !== 2'b00) begin errors++; $display("FAIL alu_fc2 got=%b exp=00", fc2); end
        checks++; if ({pcw, ifw, bub} !== 3'b110) begin errors++; $display("FAIL alu_nostall got=%b exp=110", {pcw, ifw, bub}); end
        // rs2 path: x6 now in EX, read as rs2 only
        issue(1, 5'd6, 5'd6, 0, 1, 5'd8, 1, 0);
        checks++; if (fc1 !== 2'b00) begin errors++; $display("FAIL unused_rs1 got=%b exp=00", fc1); end
        checks++; if (fc2 !== 2'b01) begin errors++; $display("FAIL alu_fc2_ex got=%b exp=01", fc2); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);   // lw x7,0(x1)
        issue(1, 5'd7, 5'd0, 1, 1, 5'd0, 0, 0);   // beq x7,x0
        checks++; if ({pcw, ifw, bub} !== 3'b001) begin errors++; $display("FAIL lu_stall got=%b exp=001", {pcw, ifw, bub}); end
        checks++; if (fc1 !== 2'b00) begin errors++; $display("FAIL lu_stall_fc1 got=%b exp=00", fc1); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL lu_cnt_before got=%0d exp=0", cnt); end
        issue(1, 5'd7, 5'd0, 1, 1, 5'd0, 0, 0);   // held beq, load now in MEM
        checks++; if ({pcw, ifw, bub} !== 3'b110) begin errors++; $display("FAIL lu_release got=%b exp=110", {pcw, ifw, bub}); end
        checks++; if (fc1 !== 2'b10) begin errors++; $display("FAIL lu_fc1_mem got=%b exp=10", fc1); end
        checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_after got=%0d exp=1", cnt); end
        // load consumed through rs2 also stalls
        issue(1, 5'd1, 5'd0, 1, 0, 5'd12, 1, 1);  // lw x12
        issue(1, 5'd1, 5'd12, 1, 1, 5'd13, 1, 0); // add x13,x1,x12
        checks++; if (bub !== 1'b1) begin errors++; $display("FAIL lu_rs2_stall got=%b exp=1", bub); end
        issue(1, 5'd1, 5'd12, 1, 1, 5'd13, 1, 0);
        checks++; if (fc2 !== 2'b10) begin errors++; $display("FAIL lu_rs2_mem got=%b exp=10", fc2); end
        checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL lu_cnt2 got=%0d exp=2", cnt); end
    endtask

    task automatic test_distance();
        do_reset();
        issue(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0);   // add x9
        issue(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);   // nop
        issue(1, 5'd9, 5'd9, 1, 1, 5'd10, 1, 0);  // distance 2 -> MEM
        checks++; if ({fc1, fc2} !== 4'b1010) begin errors++; $display("FAIL dist2 got=%b exp=1010", {fc1, fc2}); end
        do_reset();
        issue(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0);   // add x9
        issue(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);   // nop
        issue(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);   // nop
        issue(1, 5'd9, 5'd9, 1, 1, 5'd2, 1, 0);   // sub x2,x9,x9
        checks++; if (fc1 !== 2'b11) begin errors++; $display("FAIL dist3_fc1 got=%b exp=11", fc1); end
        checks++; if (fc2 !== 2'b11) begin errors++; $display("FAIL dist3_fc2 got=%b exp=11", fc2); end
        issue(1, 5'd9, 5'd9, 1, 1, 5'd2, 1, 0);   // x9 has retired
        checks++; if ({fc1, fc2} !== 4'b0000) begin errors++; $display("FAIL dist4 got=%b exp=0000", {fc1, fc2}); end
    endtask

    task automatic test_priority();
        do_reset();
        issue(1, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0);
        issue(1, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0);
        issue(1, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0);
        issue(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
        checks++; if ({fc1, fc2} !== 4'b0101) begin errors++; $display("FAIL prio_ex got=%b exp=0101", {fc1, fc2}); end
        issue(1, 5'd3, 5'd3, 1, 1, 5'd4, 0, 0);   // x3 copies now in MEM and WB
        checks++; if ({fc1, fc2} !== 4'b1010) begin errors++; $display("FAIL prio_mem got=%b exp=1010", {fc1, fc2}); end
        do_reset();
        issue(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);   // load into x0
        issue(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0);
        checks++; if ({fc1, fc2} !== 4'b0000) begin errors++; $display("FAIL x0_fwd got=%b exp=0000", {fc1, fc2}); end
        checks++; if ({pcw, ifw, bub} !== 3'b110) begin errors++; $display("FAIL x0_nostall got=%b exp=110", {pcw, ifw, bub}); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        issue(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);   // lw x7
        issue(0, 5'd7, 5'd7, 1, 1, 5'd8, 1, 1);   // flushed slot
        checks++; if ({pcw, ifw, bub} !== 3'b110) begin errors++; $display("FAIL flush_nostall got=%b exp=110", {pcw, ifw, bub}); end
        checks++; if (fc1 !== 2'b00) begin errors++; $display("FAIL flush_fc1 got=%b exp=00", fc1); end
        issue(1, 5'd8, 5'd7, 1, 1, 5'd0, 0, 0);   // flushed slot left nothing in EX
        checks++; if ({fc1, fc2} !== 4'b0010) begin errors++; $display("FAIL flush_absorb got=%b exp=0010", {fc1, fc2}); end
        checks++; if (bub !== 1'b0) begin errors++; $display("FAIL flush_absorb_bub got=%b exp=0", bub); end
        do_reset();
        issue(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);
        issue(1, 5'd7, 5'd0, 1, 1, 5'd0, 0, 0);
        checks++; if (bub !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%b exp=1", bub); end
        reset_n = 1'b0;
        #1;
        checks++; if ({pcw, ifw, bub} !== 3'b110) begin errors++; $display("FAIL rst_mid_stall got=%b exp=110", {pcw, ifw, bub}); end
        checks++; if ({fc1, fc2} !== 4'b0000) begin errors++; $display("FAIL rst_mid_fwd got=%b exp=0000", {fc1, fc2}); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got=%0d exp=0", cnt); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_saturate();
        int exp_stalls;
        do_reset();
        exp_stalls = 0;
        // lw x7,0(x7) repeated: stalls every second cycle against its own predecessor
        for (int i = 0; i < 40; i++) begin
            issue(1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1);
            checks++; if (s_cnt !== 4'((exp_stalls > 15) ? 15 : exp_stalls)) begin errors++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, s_cnt, (exp_stalls > 15) ? 15 : exp_stalls); end
            checks++; if (s_bub !== 1'(i % 2)) begin errors++; $display("FAIL sat_bub i=%0d got=%b exp=%0d", i, s_bub, i % 2); end
            if (i % 2 == 1) exp_stalls++;
        end
        issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0h exp=f", s_cnt); end
        checks++; if (cnt !== 16'(exp_stalls)) begin errors++; $display("FAIL wide_cnt got=%0d exp=%0d", cnt, exp_stalls); end
    endtask

    initial begin
        test_reset();
        test_alu_alu();
        test_load_use();
        test_distance();
        test_priority();
        test_flush_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
